// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU unary op bank: op codes, FSM states and element offsets.
// Build option MPU_UNARY_SAT_EN selects saturating instead of wrapping reduction.
package mpu_pkg;

    localparam logic [1:0] OP_NEG       = 2'b00;
    localparam logic [1:0] OP_TRANSPOSE = 2'b01;
    localparam logic [1:0] OP_SCALE     = 2'b10;
    localparam logic [1:0] OP_COPY      = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

`ifdef MPU_UNARY_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Bit offset of element (row,col) in a flat column-major matrix bus.
    function automatic int at(input int row, input int col, input int n, input int w);
        return w * (row + n * col);
    endfunction

endpackage

// File: rtl/mpu_lane_alu.sv
// One lane of the unary op bank: negate, scale or pass a single signed element.
// Out-of-range results wrap, or saturate when MPU_UNARY_SAT_EN is defined.
module mpu_lane_alu
    import mpu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] scalar,
    output logic [W-1:0] y,
    output logic         ovf
);

    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    logic signed [W:0]     neg_full;
    logic signed [2*W-1:0] prod;
    logic [W:0]            prod_top;

    assign neg_full = -$signed({a[W-1], a});
    assign prod     = $signed(a) * $signed(scalar);
    // The product fits in W bits only when its top W+1 bits are pure sign extension.
    assign prod_top = prod[2*W-1:W-1];

    always_comb begin
        y   = a;
        ovf = 1'b0;
        case (op)
            OP_NEG: begin
                ovf = neg_full[W] ^ neg_full[W-1];
                y   = neg_full[W-1:0];
                if (SAT_EN && ovf) begin
                    y = neg_full[W] ? SMIN : SMAX;
                end
            end
            OP_SCALE: begin
                ovf = !((&prod_top) || (~|prod_top));
                y   = prod[W-1:0];
                if (SAT_EN && ovf) begin
                    y = prod[2*W-1] ? SMIN : SMAX;
                end
            end
            default: begin
                y   = a;
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mpu_unary_seq.sv
// Sequential unary matrix op (negate, transpose, scale, copy) processing LANES elements per beat.
// Saturating reduction is enabled with MPU_UNARY_SAT_EN.
module mpu_unary_seq
    import mpu_pkg::*;
#(
    parameter int N     = 5,
    parameter int W     = 8,
    parameter int LANES = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [W-1:0]     scalar,
    input  logic [W*N*N-1:0] matrix_a,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [W*N*N-1:0] result
);

    localparam int NN = N * N;
    localparam int K  = (NN + LANES - 1) / LANES;
    localparam int BW = (K > 1) ? $clog2(K) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(K - 1);

    logic [1:0]      state;
    logic [BW-1:0]   beat;
    logic [W*NN-1:0] shadow_a;
    logic [1:0]      shadow_op;
    logic [W-1:0]    shadow_scalar;

    int           lane_idx   [LANES];
    int           lane_off   [LANES];
    logic         lane_valid [LANES];
    logic [W-1:0] lane_in    [LANES];
    logic [W-1:0] lane_out   [LANES];
    logic         lane_ovf   [LANES];
    logic         beat_ovf;

    // Transpose is pure operand selection: the lane reads a(col,row) for output (row,col).
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l]   = int'(beat) * LANES + l;
            lane_valid[l] = lane_idx[l] < NN;
            lane_off[l]   = 0;
            if (lane_valid[l]) begin
                if (shadow_op == OP_TRANSPOSE) begin
                    lane_off[l] = at(lane_idx[l] / N, lane_idx[l] % N, N, W);
                end else begin
                    lane_off[l] = at(lane_idx[l] % N, lane_idx[l] / N, N, W);
                end
            end
            lane_in[l] = shadow_a[lane_off[l] +: W];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mpu_lane_alu #(.W(W)) u_alu (
            .op     (shadow_op),
            .a      (lane_in[g]),
            .scalar (shadow_scalar),
            .y      (lane_out[g]),
            .ovf    (lane_ovf[g])
        );
    end

    always_comb begin
        beat_ovf = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            beat_ovf = beat_ovf | (lane_valid[l] & lane_ovf[l]);
        end
    end

    // Masked lanes past the last element never write, so result keeps its old bits there.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            beat          <= '0;
            result        <= '0;
            overflow      <= 1'b0;
            shadow_a      <= '0;
            shadow_op     <= OP_NEG;
            shadow_scalar <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shadow_a      <= matrix_a;
                        shadow_op     <= op;
                        shadow_scalar <= scalar;
                        overflow      <= 1'b0;
                        beat          <= '0;
                        state         <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        if (lane_valid[l]) begin
                            result[W*lane_idx[l] +: W] <= lane_out[l];
                        end
                    end
                    overflow <= overflow | beat_ovf;
                    if (beat == LAST_BEAT) begin
                        state <= ST_DONE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: doc/mpu_unary_seq.md
Name: mpu_unary_seq

Overview:
- Parametrised, sequential successor to the combinational 5x5 opposite operation.
- Applies a unary op to an NxN signed matrix: negate, transpose, or scalar multiply.
- Processes LANES elements per cycle under a start/busy/done handshake; sits in the MPU op bank beside the binary ops.
- Result register holds the last result until the next accepted start.

Parameters:
- N, 5, matrix dimension (rows = cols = N), N >= 2
- W, 8, element width in bits, signed two's complement
- LANES, 5, elements processed per cycle, 1 <= LANES <= N*N

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; accepted only in IDLE
- op  in  2  00 negate, 01 transpose, 10 scale, 11 reserved (treated as copy)
- scalar  in  W  signed multiplier for scale
- matrix_a  in  W*N*N  flat matrix; element (row,col) at bits [W*(row+N*col) +: W]
- busy  out  1  high while RUN
- done  out  1  one-cycle pulse on completion
- overflow  out  1  sticky per op: any element overflowed W bits
- result  out  W*N*N  flat result, same layout as matrix_a

Behaviour:
- Reset: state IDLE; busy=0, done=0, overflow=0, result all zero, beat counter 0. Applies mid-operation: abort, no done pulse.
- FSM: IDLE -> RUN on start; RUN -> DONE after last beat; DONE -> IDLE unconditionally.
- Accept (IDLE & start at edge t): latch matrix_a, op, scalar into shadow regs; clear overflow; beat counter 0; busy=1 from t+1.
- RUN: K = ceil(N*N/LANES) beats. Beat b writes flat indices b*LANES .. b*LANES+LANES-1; lanes with index >= N*N are masked (no write). Result bits not yet written keep their previous values.
- Last beat -> DONE: done=1 and busy=0 for exactly one cycle, at edge t+K+1. Defaults N=5, LANES=5: K=5, done 6 cycles after start.
- start while RUN or DONE: ignored, no queuing. start held high in IDLE is accepted again on the cycle after DONE.
- Shadow regs isolate operands: matrix_a may change after acceptance without effect.
- Negate: out = -a. Overflow when a = -2^(W-1).
- Transpose: out(row,col) = a(col,row), computed from the shadow copy; never overflows.
- Scale: full 2W-bit signed product, reduced to W bits. Overflow when the product lies outside [-2^(W-1), 2^(W-1)-1].
- Reduction without the optional feature: truncate to low W bits (wrap-around).
- overflow: ORed across all lanes and beats; stable from done until the next accept.

Optional Feature:
- Macro MPU_UNARY_SAT_EN.
- Defined: negate and scale saturate to the signed W-bit range; -(-128) = 127; 100*2 = 127; -100*2 = -128.
- Undefined: wrap-around; -(-128) = -128; 100*2 = -56.
- overflow flag behaviour is identical in both builds.

Decomposition:
- Shared package mpu_pkg: op encoding constants (OP_NEG, OP_TRANSPOSE, OP_SCALE, OP_COPY); FSM state enum; element-offset function at(row,col,N,W).
- One sub-module, mpu_lane_alu: per-lane W-bit negate/scale/pass with saturate-or-wrap and overflow out, instantiated LANES times. Transpose is index muxing at lane input, in the top.

Test Plan:
- Reset then idle: result=0, busy=0, done=0; start pulsed with reset high -> no busy.
- Negate, N=5, W=8, LANES=5, a(r,c)=r*5+c-12 -> done exactly 6 cycles after start; result(r,c)=12-(r*5+c); overflow=0.
- Negate with a(0,0)=-128 -> overflow=1; result(0,0)=127 with MPU_UNARY_SAT_EN, -128 without.
- Transpose with a(1,3)=7, a(3,1)=-9 -> result(3,1)=7, result(1,3)=-9; diagonal unchanged. Repeat with LANES=3 -> K=9, done at cycle 10, masked lane writes nothing past index 24.
- Scale scalar=2, a(2,2)=100, a(4,0)=-3 -> result(4,0)=-6; result(2,2)=127 sat / -56 wrap; overflow=1.
- Robustness:
  - start re-asserted and matrix_a changed during RUN -> ignored; result reflects the latched operands.
  - reset at beat 2 -> IDLE next cycle, result=0, no done pulse.
